// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: forwarding, load-use, MDU stall and branch-flush control; HAZ_PERF_EN adds stall_cycles
module hazard_forward_unit #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int MDU_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_mem_regwrite,
  input  logic [AW-1:0]          ex_mem_rd,
  input  logic                   mem_wb_regwrite,
  input  logic [AW-1:0]          mem_wb_rd,
  input  logic [NUM_SRC*AW-1:0]  id_ex_rs,
  input  logic                   id_ex_memread,
  input  logic [AW-1:0]          id_ex_rd,
  input  logic [NUM_SRC*AW-1:0]  if_id_rs,
  input  logic [NUM_SRC-1:0]     if_id_rs_used,
  input  logic                   ex_mdu_start,
  input  logic                   ex_branch_taken,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic                   pc_write_en,
  output logic                   if_id_write_en,
  output logic                   id_ex_write_en,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_bubble,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   mdu_busy,
  output logic                   mdu_done
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);
  localparam int CW = $clog2(MDU_LAT) + 1;
  logic [CW-1:0] cnt;
  logic done_r;
  logic [NUM_SRC-1:0] lu_src;
  logic lu, accept, mdu_stall, hold, lu_stall;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign fwd_sel[2*i +: 2] =
      (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == id_ex_rs[i*AW +: AW]) ? 2'b10 :
      (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == id_ex_rs[i*AW +: AW]) ? 2'b01 : 2'b00;
    assign lu_src[i] = if_id_rs_used[i] && if_id_rs[i*AW +: AW] == id_ex_rd;
  end
  assign lu        = id_ex_memread && id_ex_rd != '0 && |lu_src;
  // done_r blocks re-acceptance so the MDU op still held in EX does not restart
  assign accept    = ex_mdu_start && cnt == '0 && !done_r && !ex_branch_taken;
  assign mdu_stall = accept || cnt != '0;
  assign hold      = !ex_branch_taken && mdu_stall;
  assign lu_stall  = !ex_branch_taken && !mdu_stall && lu;
  assign pc_write_en    = !(hold || lu_stall);
  assign if_id_write_en = !(hold || lu_stall);
  assign id_ex_write_en = !hold;
  assign id_ex_bubble   = lu_stall;
  assign ex_mem_bubble  = hold;
  assign if_id_flush    = ex_branch_taken;
  assign id_ex_flush    = ex_branch_taken;
  assign mdu_busy       = cnt != '0;
  assign mdu_done       = done_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= (accept && MDU_LAT == 1) || cnt == CW'(1);
      cnt    <= accept ? CW'(MDU_LAT - 1) : (cnt != '0) ? cnt - 1'b1 : cnt;
    end
  end
`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (!pc_write_en && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed and random checks against a cycle-timestamp reference model
module tb_hazard_forward_unit;
  localparam int AW = 5, NS = 2, LAT = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_mem_regwrite = 0, mem_wb_regwrite = 0, id_ex_memread = 0, ex_mdu_start = 0, ex_branch_taken = 0;
  logic [AW-1:0] ex_mem_rd = '0, mem_wb_rd = '0, id_ex_rd = '0;
  logic [NS*AW-1:0] id_ex_rs = '0, if_id_rs = '0;
  logic [NS-1:0] if_id_rs_used = '0;
  logic [2*NS-1:0] fwd_sel;
  logic pc_write_en, if_id_write_en, id_ex_write_en, id_ex_bubble, ex_mem_bubble;
  logic if_id_flush, id_ex_flush, mdu_busy, mdu_done;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles;
`endif
  int total = 0, bad = 0, cyc = 0, op_start = -1, perf = 0;
  always #5 clk = ~clk;
  hazard_forward_unit #(.AW(AW), .NUM_SRC(NS), .MDU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
    .id_ex_rs(id_ex_rs), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
    .ex_mdu_start(ex_mdu_start), .ex_branch_taken(ex_branch_taken),
    .fwd_sel(fwd_sel), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_ex_write_en(id_ex_write_en), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef HAZ_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [2*NS-1:0] exp_fwd();
    logic [2*NS-1:0] r = '0;
    for (int i = 0; i < NS; i++) begin
      int rs = int'(id_ex_rs[i*AW +: AW]);
      if (ex_mem_regwrite && ex_mem_rd != 0 && int'(ex_mem_rd) == rs) r[2*i +: 2] = 2'b10;
      else if (mem_wb_regwrite && mem_wb_rd != 0 && int'(mem_wb_rd) == rs) r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction
  function automatic logic exp_lu();
    logic hit = 1'b0;
    for (int i = 0; i < NS; i++)
      if (if_id_rs_used[i] && if_id_rs[i*AW +: AW] == id_ex_rd) hit = 1'b1;
    return id_ex_memread && id_ex_rd != 0 && hit;
  endfunction
  function automatic logic m_idle();
    return op_start < 0 || cyc > op_start + LAT;
  endfunction
  function automatic logic m_accept();
    return ex_mdu_start && !ex_branch_taken && m_idle();
  endfunction
  function automatic logic [8:0] exp_ctrl();
    logic st = m_accept() || (op_start >= 0 && cyc < op_start + LAT);
    logic busy = op_start >= 0 && cyc > op_start && cyc < op_start + LAT;
    logic done = op_start >= 0 && cyc == op_start + LAT;
    if (ex_branch_taken) return {7'b1110011, busy, done};
    if (st) return {7'b0000100, busy, done};
    if (exp_lu()) return {7'b0011000, busy, done};
    return {7'b1110000, busy, done};
  endfunction
  task automatic check_all(input string tag);
    #1;
    chk({tag, "_fwd"}, 32'(fwd_sel), 32'(exp_fwd()));
    chk({tag, "_ctrl"}, 32'({pc_write_en, if_id_write_en, id_ex_write_en, id_ex_bubble, ex_mem_bubble,
                             if_id_flush, id_ex_flush, mdu_busy, mdu_done}), 32'(exp_ctrl()));
`ifdef HAZ_PERF_EN
    chk({tag, "_perf"}, stall_cycles, 32'(perf));
`endif
  endtask
  task automatic tick();
    logic [8:0] e = exp_ctrl();
    if (m_accept()) op_start = cyc;
    if (!e[8]) perf++;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    op_start = -1;
    perf = 0;
    check_all("rst");
    chk("rst_busy", 32'(mdu_busy), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  initial begin
    do_reset();
    ex_mem_regwrite = 1; ex_mem_rd = 5; mem_wb_regwrite = 1; mem_wb_rd = 5;
    id_ex_rs = {5'd6, 5'd5};
    check_all("fwd_pri");
    chk("fwd_pri_exact", 32'(fwd_sel), 32'h2);
    ex_mem_rd = 7;
    check_all("fwd_wb");
    chk("fwd_wb_exact", 32'(fwd_sel), 32'h1);
    ex_mem_rd = 0; mem_wb_rd = 0; id_ex_rs = '0;
    check_all("x0");
    chk("x0_exact", 32'(fwd_sel), 32'h0);
    id_ex_memread = 1; id_ex_rd = 3; if_id_rs = {5'd3, 5'd0}; if_id_rs_used = 2'b10;
    check_all("lu");
    chk("lu_exact", 32'({pc_write_en, if_id_write_en, id_ex_write_en, id_ex_bubble}), 32'b0011);
    tick();
    id_ex_memread = 0;
    check_all("lu_after");
    chk("lu_after_pc", 32'(pc_write_en), 32'd1);
    id_ex_memread = 1; if_id_rs_used = 2'b01;
    check_all("lu_unused");
    chk("lu_unused_pc", 32'(pc_write_en), 32'd1);
    if_id_rs_used = 2'b10; ex_branch_taken = 1;
    check_all("br_lu");
    chk("br_lu_exact", 32'({if_id_flush, id_ex_flush, pc_write_en, id_ex_bubble}), 32'b1110);
    ex_branch_taken = 0; id_ex_memread = 0;
    do_reset();
    ex_mdu_start = 1;
    for (int k = 0; k < LAT; k++) begin
      check_all("mdu_stall");
      chk("mdu_stall_exact", 32'({pc_write_en, ex_mem_bubble, mdu_done}), 32'b010);
      tick();
    end
    check_all("mdu_done");
    chk("mdu_done_exact", 32'({pc_write_en, ex_mem_bubble, mdu_done}), 32'b101);
    ex_mdu_start = 0;
`ifdef HAZ_PERF_EN
    chk("perf_op", stall_cycles, 32'd4);
`endif
    tick();
    check_all("mdu_idle");
    ex_mdu_start = 1;
    check_all("mid_start");
    tick();
    tick();
    ex_mdu_start = 0;
    check_all("mid_cnt2");
    chk("mid_busy", 32'(mdu_busy), 32'd1);
    rst_n = 1'b0;
    op_start = -1;
    perf = 0;
    check_all("mid_rst");
    chk("mid_rst_exact", 32'({mdu_busy, pc_write_en}), 32'b01);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < 400; n++) begin
      ex_mem_regwrite = 1'($urandom);
      mem_wb_regwrite = 1'($urandom);
      ex_mem_rd = AW'($urandom_range(0, 3));
      mem_wb_rd = AW'($urandom_range(0, 3));
      id_ex_rd = AW'($urandom_range(0, 3));
      id_ex_memread = 1'($urandom);
      for (int i = 0; i < NS; i++) begin
        id_ex_rs[i*AW +: AW] = AW'($urandom_range(0, 3));
        if_id_rs[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      if_id_rs_used = NS'($urandom);
      ex_mdu_start = $urandom_range(0, 3) == 0;
      ex_branch_taken = $urandom_range(0, 7) == 0;
      check_all("rand");
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It generalises operand forwarding to NUM_SRC source operands and adds three functions:
- load-use stall detection
- a multi-cycle MDU (mul/div) stall sequencer with a latency counter
- branch-flush control

It sits beside the ID/EX and EX/MEM pipeline registers and drives the PC and pipeline-register enables, bubbles and flushes.

Parameters:
AW, 5, register-address width
NUM_SRC, 2, source operands per instruction (1..3)
MDU_LAT, 4, cycles an MDU op occupies EX (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_mem_regwrite  in  1  EX/MEM instruction writes rd
ex_mem_rd  in  AW  EX/MEM destination
mem_wb_regwrite  in  1  MEM/WB instruction writes rd
mem_wb_rd  in  AW  MEM/WB destination
id_ex_rs  in  NUM_SRC*AW  EX-stage sources; source i at bits [i*AW +: AW]
id_ex_memread  in  1  EX-stage instruction is a load
id_ex_rd  in  AW  EX-stage destination
if_id_rs  in  NUM_SRC*AW  ID-stage sources
if_id_rs_used  in  NUM_SRC  ID-stage source i is actually read
ex_mdu_start  in  1  EX-stage instruction is an MDU op
ex_branch_taken  in  1  EX resolves a taken branch or jump
fwd_sel  out  2*NUM_SRC  per-source forward select, [2i+:2]
pc_write_en  out  1  PC update enable
if_id_write_en  out  1  IF/ID enable
id_ex_write_en  out  1  ID/EX enable
id_ex_bubble  out  1  load NOP into ID/EX
ex_mem_bubble  out  1  load NOP into EX/MEM
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  clear ID/EX
mdu_busy  out  1  MDU counter non-zero
mdu_done  out  1  one-cycle pulse: MDU result valid in EX

Behaviour:
Forwarding (combinational, per source i; rs_i is id_ex_rs source i):
- fwd_sel = 2'b10 if ex_mem_regwrite, ex_mem_rd != 0 and ex_mem_rd == rs_i.
- Otherwise fwd_sel = 2'b01 if mem_wb_regwrite, mem_wb_rd != 0 and mem_wb_rd == rs_i.
- Otherwise fwd_sel = 2'b00.
- Priority: EX/MEM over MEM/WB. x0 is never forwarded.

Load-use hazard (combinational):
- lu = id_ex_memread && id_ex_rd != 0 && (for some i: if_id_rs_used[i] && if_id_rs source i == id_ex_rd).

MDU sequencer (state: cnt [clog2(MDU_LAT)+1 bits], done_r):
- Reset: cnt = 0, done_r = 0.
- Start accepted when ex_mdu_start && cnt == 0 && !done_r && !ex_branch_taken.
- On accept: if MDU_LAT == 1, set done_r; otherwise cnt <= MDU_LAT-1.
- While cnt != 0: cnt decrements each cycle. The 1->0 transition sets done_r.
- done_r is set for exactly one cycle, then cleared.
- While done_r is set, ex_mdu_start is ignored so the held instruction does not re-trigger.
- mdu_stall = accept || cnt != 0. This gives exactly MDU_LAT stall cycles.
- mdu_busy = (cnt != 0). mdu_done = done_r.

Output combination, in priority order:
1. ex_branch_taken: if_id_flush = id_ex_flush = 1. lu is ignored. All enables = 1. Bubbles = 0. No MDU start.
2. mdu_stall: pc_write_en = if_id_write_en = id_ex_write_en = 0, ex_mem_bubble = 1, id_ex_bubble = 0. lu is ignored.
3. lu: pc_write_en = if_id_write_en = 0, id_ex_write_en = 1, id_ex_bubble = 1 for one cycle.
4. Otherwise: all enables = 1, bubbles = 0, flushes = 0.

Additional rules:
- ex_branch_taken together with ex_mdu_start is illegal. The flush wins.
- Reset mid-MDU clears cnt and done_r immediately. mdu_stall then drops asynchronously.
- During reset, the combinational outputs still track their inputs with cnt = 0.

Optional Feature:
Macro: HAZ_PERF_EN.
- Defined: adds output stall_cycles [31:0].
  - Resets to 0.
  - Increments on each clock where pc_write_en == 0.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Forwarding priority: ex_mem_regwrite=1, ex_mem_rd=5, mem_wb_regwrite=1, mem_wb_rd=5, rs0=5, rs1=6 -> fwd_sel[1:0]=10, fwd_sel[3:2]=00. Then ex_mem_rd=7 -> fwd_sel[1:0]=01.
- x0 guard: all rd=0, rs=0, regwrite=1 -> fwd_sel=0.
- Load-use: id_ex_memread=1, id_ex_rd=3, if_id_rs source 1=3, if_id_rs_used=2'b10 -> pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 for 1 cycle. Same with if_id_rs_used=2'b01 -> no stall.
- MDU with MDU_LAT=4: hold ex_mdu_start=1 -> pc_write_en=0 for exactly 4 cycles, ex_mem_bubble=1 for those 4, mdu_done=1 in cycle 5 with stall released, no re-trigger.
- Branch flush during a load-use condition: ex_branch_taken=1 with lu=1 -> flushes=1, pc_write_en=1, id_ex_bubble=0.
- Reset mid-MDU: assert rst_n=0 at cnt=2 -> mdu_busy=0 and stall dropped without a clock. HAZ_PERF_EN build: stall_cycles=0 after reset, then 4 after one MDU op.
